// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO behind the UART receiver. It acknowledges each byte
// through a two-state handshake FSM and offers a show-ahead pop interface.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_data_interrupt,
    input  logic [DATA_W-1:0] data,
    output logic              disable_data_interrupt,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    input  logic              clr_overflow
);

    typedef enum logic {
        IDLE,
        ACK
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W+1)'(DEPTH);

    state_t              state;
    state_t              next_state;
    logic                wr_attempt;
    logic                do_write;
    logic                do_pop;
    logic                drop;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [DATA_W-1:0]   mem [DEPTH];

    // One write attempt per handshake: only the IDLE->ACK transition writes.
    always_comb begin
        next_state = state;
        wr_attempt = 1'b0;
        case (state)
            IDLE: begin
                if (enable_data_interrupt) begin
                    wr_attempt = 1'b1;
                    next_state = ACK;
                end
            end
            ACK: begin
                if (!enable_data_interrupt) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    assign disable_data_interrupt = (state == ACK);

    assign empty    = (count == '0);
    assign full     = (count == FULL_COUNT);
    assign do_pop   = rd_en && !empty;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign do_write = wr_attempt && (!full || rd_en);
    assign drop     = wr_attempt && full && !rd_en;

    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[wr_ptr] <= data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_write, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Setting has priority over clearing so a drop is never lost.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    assign rd_data = empty ? '0 : mem[rd_ptr];

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo: reset, handshake, ordering
// with pointer wrap, overflow, full-with-pop, and clear-versus-set priority.
module tb_uart_rx_fifo;

    logic       clk;
    logic       rst;
    logic       enable_data_interrupt;
    logic [7:0] data;
    logic       disable_data_interrupt;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] count;
    logic       overflow;
    logic       clr_overflow;

    int total = 0;
    int bad   = 0;
    logic ack;
    int ack_cycles;

    uart_rx_fifo #(.DATA_W(8), .DEPTH(16), .ADDR_W(4)) dut (
        .clk                    (clk),
        .rst                    (rst),
        .enable_data_interrupt  (enable_data_interrupt),
        .data                   (data),
        .disable_data_interrupt (disable_data_interrupt),
        .rd_en                  (rd_en),
        .rd_data                (rd_data),
        .empty                  (empty),
        .full                   (full),
        .count                  (count),
        .overflow               (overflow),
        .clr_overflow           (clr_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Full receiver handshake, called at a falling edge; optional pop/clear in the write cycle.
    task automatic apply_stimulus(input logic [7:0] b, input logic pop, input logic clr, output logic acked);
        data                  = b;
        enable_data_interrupt = 1'b1;
        rd_en                 = pop;
        clr_overflow          = clr;
        @(negedge clk);
        acked                 = disable_data_interrupt;
        rd_en                 = 1'b0;
        clr_overflow          = 1'b0;
        enable_data_interrupt = 1'b0;
        @(negedge clk);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] exp);
        check_output(tag, 32'(rd_data), 32'(exp));
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        rst                   = 1'b0;
        enable_data_interrupt = 1'b0;
        data                  = 8'h00;
        rd_en                 = 1'b0;
        clr_overflow          = 1'b0;
        @(negedge clk);
        check_output("rst_empty", 32'(empty), 32'd1);
        check_output("rst_count", 32'(count), 32'd0);
        check_output("rst_full", 32'(full), 32'd0);
        check_output("rst_ovf", 32'(overflow), 32'd0);
        check_output("rst_rd_data", 32'(rd_data), 32'h00);
        check_output("rst_ack", 32'(disable_data_interrupt), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        $display("[TB] async reset mid-handshake");
        apply_stimulus(8'h11, 1'b0, 1'b0, ack);
        check_output("pre_count", 32'(count), 32'd1);
        data                  = 8'h3C;
        enable_data_interrupt = 1'b1;
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check_output("arst_ack", 32'(disable_data_interrupt), 32'd0);
        check_output("arst_empty", 32'(empty), 32'd1);
        check_output("arst_count", 32'(count), 32'd0);
        check_output("arst_rd_data", 32'(rd_data), 32'h00);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_output("rel_count", 32'(count), 32'd1);
        check_output("rel_rd_data", 32'(rd_data), 32'h3C);
        check_output("rel_ack", 32'(disable_data_interrupt), 32'd1);
        enable_data_interrupt = 1'b0;
        @(negedge clk);
        check_output("rel_ack_low", 32'(disable_data_interrupt), 32'd0);
        pop_check("rel_pop", 8'h3C);
        check_output("rel_empty", 32'(empty), 32'd1);

        $display("[TB] single byte, long enable");
        data                  = 8'hAA;
        enable_data_interrupt = 1'b1;
        ack_cycles            = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (disable_data_interrupt) ack_cycles++;
        end
        enable_data_interrupt = 1'b0;
        @(negedge clk);
        if (disable_data_interrupt) ack_cycles++;
        check_output("sb_ack_cycles", 32'(ack_cycles), 32'd5);
        check_output("sb_ack_low", 32'(disable_data_interrupt), 32'd0);
        check_output("sb_count", 32'(count), 32'd1);
        pop_check("sb_rd_data", 8'hAA);
        check_output("sb_empty", 32'(empty), 32'd1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check_output("underflow_count", 32'(count), 32'd0);

        $display("[TB] ordering and wrap");
        for (int i = 1; i <= 8; i++) apply_stimulus(8'(i), 1'b0, 1'b0, ack);
        for (int i = 1; i <= 4; i++) pop_check("ord_pop_a", 8'(i));
        for (int i = 9; i <= 20; i++) apply_stimulus(8'(i), 1'b0, 1'b0, ack);
        check_output("ord_count_peak", 32'(count), 32'd16);
        check_output("ord_full", 32'(full), 32'd1);
        check_output("ord_ovf", 32'(overflow), 32'd0);
        for (int i = 5; i <= 20; i++) pop_check("ord_pop_b", 8'(i));
        check_output("ord_empty", 32'(empty), 32'd1);

        $display("[TB] overflow");
        for (int i = 0; i < 16; i++) apply_stimulus(8'(i), 1'b0, 1'b0, ack);
        check_output("ovf_full", 32'(full), 32'd1);
        check_output("ovf_pre", 32'(overflow), 32'd0);
        apply_stimulus(8'h10, 1'b0, 1'b0, ack);
        check_output("ovf_acked", 32'(ack), 32'd1);
        check_output("ovf_flag", 32'(overflow), 32'd1);
        check_output("ovf_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) pop_check("ovf_pop", 8'(i));
        check_output("ovf_empty", 32'(empty), 32'd1);
        check_output("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check_output("ovf_clr", 32'(overflow), 32'd0);

        $display("[TB] full with simultaneous pop");
        for (int i = 0; i < 16; i++) apply_stimulus(8'(8'h20 + i), 1'b0, 1'b0, ack);
        apply_stimulus(8'h55, 1'b1, 1'b0, ack);
        check_output("fp_count", 32'(count), 32'd16);
        check_output("fp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) pop_check("fp_pop", 8'(8'h20 + i));
        pop_check("fp_last", 8'h55);
        check_output("fp_empty", 32'(empty), 32'd1);

        $display("[TB] clear versus set");
        for (int i = 0; i < 16; i++) apply_stimulus(8'(8'h60 + i), 1'b0, 1'b0, ack);
        apply_stimulus(8'h70, 1'b0, 1'b0, ack);
        check_output("cs_set", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        @(negedge clk);
        clr_overflow = 1'b0;
        check_output("cs_clr", 32'(overflow), 32'd0);
        apply_stimulus(8'h71, 1'b0, 1'b1, ack);
        check_output("cs_set_wins", 32'(overflow), 32'd1);
        check_output("cs_head", 32'(rd_data), 32'h60);

        rst = 1'b0;
        #1;
        check_output("burst_rst_count", 32'(count), 32'd0);
        check_output("burst_rst_ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
